// File: rtl/sample_queue.sv
// Dual-channel circular sample buffer: captures one stereo pair per wrt_smpl rising
// edge and, once READ_LEN samples are held, streams the newest READ_LEN pairs oldest-first.
module sample_queue #(
   parameter int DEPTH    = 1024,
   parameter int READ_LEN = 1021
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt_smpl,
   input  logic [15:0] lft_smpl,
   input  logic [15:0] rht_smpl,
   output logic        sequencing,
   output logic [15:0] lft_out,
   output logic [15:0] rht_out,
   output logic        ovr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(READ_LEN + 1);
   localparam logic [CW-1:0] FULL = CW'(READ_LEN);
   localparam logic [CW-1:0] LAST = CW'(READ_LEN - 1);

   typedef enum logic {IDLE, READ} state_t;

   state_t        r_state;
   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rd_data;
   logic [AW-1:0] r_new_ptr;
   logic [AW-1:0] r_old_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_rd_cnt;
   logic          r_wrt_prev;
   logic          r_rd_vld;
   logic          w_wr_evt;
   logic          w_wr_acc;
   logic          w_rd_en;

   assign w_wr_evt = wrt_smpl & ~r_wrt_prev;
   assign w_wr_acc = w_wr_evt & (r_state == IDLE);
   assign w_rd_en  = (r_state == READ);

   // Storage and its registered read port carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_mem[r_new_ptr] <= {lft_smpl, rht_smpl};
      if (w_rd_en)
         r_rd_data <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_wrt_prev <= 1'b1;
         r_new_ptr  <= '0;
         r_old_ptr  <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_cnt   <= '0;
         r_rd_vld   <= 1'b0;
         sequencing <= 1'b0;
         lft_out    <= '0;
         rht_out    <= '0;
         ovr        <= 1'b0;
      end else begin
         r_wrt_prev <= wrt_smpl;
         r_rd_vld   <= w_rd_en;
         sequencing <= r_rd_vld;
         if (r_rd_vld)
            {lft_out, rht_out} <= r_rd_data;
         // A sample arriving while a burst is running is discarded and flagged.
         if (w_wr_evt && (r_state != IDLE))
            ovr <= 1'b1;

         case (r_state)
            IDLE: begin
               if (w_wr_acc) begin
                  r_new_ptr <= r_new_ptr + 1'b1;
                  if (r_count != FULL)
                     r_count <= r_count + 1'b1;
                  if (r_count >= LAST) begin
                     r_state  <= READ;
                     r_rd_ptr <= r_old_ptr;
                     r_rd_cnt <= '0;
                  end
               end
            end
            READ: begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
               if (r_rd_cnt == LAST) begin
                  r_state   <= IDLE;
                  r_old_ptr <= r_old_ptr + 1'b1;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
